async_fifo_wr_ctrl: RTL

Write-domain controller for the asynchronous FIFO. It owns the write pointer in binary and Gray form and drives the dual-port memory's write address and enable. It consumes the read pointer after the read-domain Gray pointer has passed through the two-flop pointer synchronizer clocked by the write clock. From that it generates FULL, ALMOST_FULL, a fill level and a sticky overflow flag. Its registered Gray pointer is the value the read-domain synchronizer samples.

---
 rtl/async_fifo_wr_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller for the asynchronous FIFO.
// Owns the binary/Gray write pointer, drives the memory write port and
// derives FULL, ALMOST_FULL, fill level and a sticky overflow flag from the
// read pointer that has already been synchronized into CLK.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_THR  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_INC,
    input  logic [ADDR_WIDTH:0]   RD_PTR_SYNC,
    input  logic                  OVF_CLR,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   WR_LEVEL,
    output logic                  OVERFLOW
);
    localparam int A = ADDR_WIDTH;
    localparam logic [A:0] AFULL_THR_W = (A+1)'(AFULL_THR);

    logic [A:0] wr_bin, wr_gray;
    logic [A:0] wr_bin_next, wr_gray_next;
    logic [A:0] rd_bin;
    logic [A:0] level_next;
    logic [A:0] full_cmp;
    logic       full_q, afull_q, ovf_q;
    logic [A:0] level_q;

    // FULL is registered, so a write in the cycle after FULL rises is refused.
    assign WR_EN = WR_INC & ~full_q;

    // Next pointer values: advance only on an accepted write.
    always_comb begin
        wr_bin_next  = wr_bin + {{A{1'b0}}, WR_EN};
        wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    end

    // Gray-to-binary of the synchronized read pointer: each bit is the XOR of itself and all higher Gray bits.
    always_comb begin
        rd_bin    = RD_PTR_SYNC;
        for (int i = A - 1; i >= 0; i--) begin
            rd_bin[i] = rd_bin[i+1] ^ RD_PTR_SYNC[i];
        end
    end

    // Occupancy from the (possibly stale) read pointer; modulo arithmetic survives the wrap.
    always_comb begin
        level_next = wr_bin_next - rd_bin;
        // Full when the pointers differ only in the wrap bit, expressed in Gray form.
        full_cmp   = {~RD_PTR_SYNC[A:A-1], RD_PTR_SYNC[A-2:0]};
    end

    // Pointer, flag and level registers; all clear asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_bin  <= '0;
            wr_gray <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_bin  <= wr_bin_next;
            wr_gray <= wr_gray_next;
            level_q <= level_next;
            full_q  <= (wr_gray_next == full_cmp);
            afull_q <= (level_next >= AFULL_THR_W);
            // A refused write sets the sticky flag; set wins over clear.
            if (WR_INC && full_q)
                ovf_q <= 1'b1;
            else if (OVF_CLR)
                ovf_q <= 1'b0;
        end
    end

    // The Gray pointer leaves straight from a flop so the crossing sees one-bit changes only.
    assign WR_ADDR     = wr_bin[A-1:0];
    assign WR_PTR_GRAY = wr_gray;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign WR_LEVEL    = level_q;
    assign OVERFLOW    = ovf_q;

endmodule
